// File: rtl/face_preprocess_pkg.sv
// Shared constants for the face-detection pre-processing stage: FSM encodings,
// 3x3 Gaussian kernel table and datapath widths.
package face_preprocess_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int ACC_W     = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Tap k (raster order, k = 3*dr + dc) occupies bits [3k +: 3]
    localparam logic [26:0] KERNEL_W = {3'd1, 3'd2, 3'd1,
                                        3'd2, 3'd4, 3'd2,
                                        3'd1, 3'd2, 3'd1};

    function automatic logic [2:0] tap_weight(input logic [3:0] tap);
        return KERNEL_W[3*tap +: 3];
    endfunction

endpackage

// File: rtl/face_pp_addr_gen.sv
// Raster row/col and 3x3 tap counters; produces the neighbour read address,
// the centre write address, the tap weight and border/first/last flags.
module face_pp_addr_gen
    import face_preprocess_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int AW         = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_clr_i,
    input  logic          tap_adv_i,
    input  logic          pix_adv_i,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] pix_addr_o,
    output logic [2:0]    weight_o,
    output logic          border_o,
    output logic          first_tap_o,
    output logic          last_tap_o,
    output logic          last_pixel_o
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    tr_q, tr_d, tc_q, tc_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        tr_d  = tr_q;
        tc_d  = tc_q;
        if (frame_clr_i) begin
            row_d = '0;
            col_d = '0;
            tr_d  = '0;
            tc_d  = '0;
        end else if (pix_adv_i) begin
            tr_d = '0;
            tc_d = '0;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (tap_adv_i) begin
            if (tc_q == 2'd2) begin
                tc_d = '0;
                tr_d = tr_q + 2'd1;
            end else begin
                tc_d = tc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
            tr_q  <= '0;
            tc_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            tr_q  <= tr_d;
            tc_q  <= tc_d;
        end
    end

    assign border_o     = (row_q == '0) || (row_q == ROW_LAST) ||
                          (col_q == '0) || (col_q == COL_LAST);
    assign first_tap_o  = (tr_q == 2'd0) && (tc_q == 2'd0);
    assign last_tap_o   = border_o || ((tr_q == 2'd2) && (tc_q == 2'd2));
    assign last_pixel_o = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign weight_o     = tap_weight(4'(tr_q) * 4'd3 + 4'(tc_q));

    assign pix_addr_o = AW'(row_q) * AW'(IMG_WIDTH) + AW'(col_q);
    // Offset (tr-1, tc-1) from the centre; only meaningful for interior pixels
    assign rd_addr_o  = border_o ? pix_addr_o
                      : pix_addr_o + AW'(tr_q) * AW'(IMG_WIDTH) + AW'(tc_q) - AW'(IMG_WIDTH + 1);

endmodule

// File: rtl/face_preprocess.sv
// 3x3 Gaussian smoothing of one frame from img_mem into out_mem, start/done handshake.
// Optional FACE_PREPROCESS_BINARIZE_EN thresholds every written pixel against THRESH.
module face_preprocess
    import face_preprocess_pkg::*;
#(
    parameter int               IMG_WIDTH  = 64,
    parameter int               IMG_HEIGHT = 64,
    parameter int               PIX_W      = PIX_W_DEF,
    parameter logic [PIX_W-1:0] THRESH     = PIX_W'(8'h80)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW   = $clog2(NPIX);
`ifdef FACE_PREPROCESS_BINARIZE_EN
    localparam bit BINARIZE = 1'b1;
`else
    localparam bit BINARIZE = 1'b0;
`endif

    logic [PIX_W-1:0] img_mem [0:NPIX-1];
    logic [PIX_W-1:0] out_mem [0:NPIX-1];

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             frame_clr, tap_adv, pix_adv, wr_en;
    logic [AW-1:0]    rd_addr, pix_addr;
    logic [2:0]       weight;
    logic             border, first_tap, last_tap, last_pixel;
    logic [PIX_W-1:0] pix, result, wr_data;

    face_pp_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .AW         (AW)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .frame_clr_i  (frame_clr),
        .tap_adv_i    (tap_adv),
        .pix_adv_i    (pix_adv),
        .rd_addr_o    (rd_addr),
        .pix_addr_o   (pix_addr),
        .weight_o     (weight),
        .border_o     (border),
        .first_tap_o  (first_tap),
        .last_tap_o   (last_tap),
        .last_pixel_o (last_pixel)
    );

    assign pix = img_mem[rd_addr];

    always_comb begin
        result = border ? acc_q[PIX_W-1:0] : acc_q[ACC_W-1 -: PIX_W];
        if (BINARIZE) begin
            wr_data = (result >= THRESH) ? '1 : '0;
        end else begin
            wr_data = result;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        acc_d     = acc_q;
        frame_clr = 1'b0;
        tap_adv   = 1'b0;
        pix_adv   = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ACCUM;
                    done_d    = 1'b0;
                    frame_clr = 1'b1;
                end
            end
            ST_ACCUM: begin
                // Border pixels are copied; interior taps restart the sum on tap 0
                if (border) begin
                    acc_d = ACC_W'(pix);
                end else begin
                    acc_d = (first_tap ? '0 : acc_q) + ACC_W'(pix) * ACC_W'(weight);
                end
                if (last_tap) begin
                    state_d = ST_WRITE;
                end else begin
                    tap_adv = 1'b1;
                end
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                pix_adv = 1'b1;
                acc_d   = '0;
                if (last_pixel) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            out_mem[pix_addr] <= wr_data;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_face_preprocess.sv
// Self-checking bench for face_preprocess: random and directed frames compared
// against a plain-arithmetic convolution model, plus reset/start handshake checks.
module tb_face_preprocess;
    import face_preprocess_pkg::*;

    localparam int W         = 64;
    localparam int H         = 64;
    localparam int N         = W * H;
    localparam int NINT      = (W - 2) * (H - 2);
    localparam int FRAME_CYC = NINT * 10 + (N - NINT) * 2;
    localparam int LIMIT     = FRAME_CYC + 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic done;

    int checks = 0;
    int errors = 0;
    int ncyc;

    logic [7:0] img  [N];
    logic [7:0] expv [N];
    logic [7:0] prev [N];

    always #5 clk = ~clk;

    face_preprocess dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] binf(input logic [7:0] v);
`ifdef FACE_PREPROCESS_BINARIZE_EN
        return (v >= 8'h80) ? 8'hFF : 8'h00;
`else
        return v;
`endif
    endfunction

    // Gaussian 1-2-1 outer product, divided by 16; borders copied
    task automatic build_model();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    expv[r*W+c] = binf(img[r*W+c]);
                end else begin
                    int s = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            s += int'(img[(r+dr)*W + c + dc]) * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                    expv[r*W+c] = binf(8'(s / 16));
                end
            end
        end
    endtask

    task automatic load_img();
        for (int i = 0; i < N; i++) dut.img_mem[i] = img[i];
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done; one stray start pulse injected
    task automatic wait_done(input int stray_at, output int n);
        n = 0;
        while (!done && n < LIMIT) begin
            start = (n == stray_at);
            tick(1);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_%0d", tag, i), 32'(dut.out_mem[i]), 32'(expv[i]));
    endtask

    initial begin
        tick(3);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        tick(2);
        check("idle_done", 32'(done), 0);

        // Run 1: random frame, stray start mid-frame must be ignored
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        img[0]   = 8'hC3;
        img[N-1] = 8'h5A;
        load_img();
        build_model();
        pulse_start();
        wait_done(300, ncyc);
        check("run1_latency", 32'(ncyc), 32'(FRAME_CYC));
        check("run1_done", 32'(done), 1);
        check_frame("run1_out");
        for (int i = 0; i < N; i++) prev[i] = expv[i];
        tick(5);
        check("run1_done_held", 32'(done), 1);

        // Run 2: directed impulse/border frame, interrupted by reset+start after 1000 cycles
        for (int i = 0; i < N; i++) img[i] = 8'h00;
        img[10*W+10] = 8'hFF;
        img[0*W+5]   = 8'hAB;
        img[N-1]     = 8'h12;
        load_img();
        build_model();
        pulse_start();
        check("restart_done_drop", 32'(done), 0);
        tick(1000);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("midrst_done", 32'(done), 0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        tick(5);
        check("midrst_still_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("midrst_partial_written", 32'(dut.out_mem[0]), 32'(expv[0]));
        check("midrst_retained", 32'(dut.out_mem[N-1]), 32'(prev[N-1]));

        pulse_start();
        wait_done(5000, ncyc);
        check("run2_latency", 32'(ncyc), 32'(FRAME_CYC));
        check("run2_done", 32'(done), 1);
        check("imp_centre", 32'(dut.out_mem[10*W+10]), 32'(binf(8'h3F)));
        check("imp_edge", 32'(dut.out_mem[9*W+10]), 32'(binf(8'h1F)));
        check("imp_corner", 32'(dut.out_mem[9*W+9]), 32'(binf(8'h0F)));
        check("border_top", 32'(dut.out_mem[5]), 32'(binf(8'hAB)));
        check("border_last", 32'(dut.out_mem[N-1]), 32'(binf(8'h12)));
        check_frame("run2_out");

        // Run 3: restart from DONE drops done on the sampling edge, then reset aborts
        pulse_start();
        check("rerun_done_drop", 32'(done), 0);
        tick(20);
        check("rerun_busy_done", 32'(done), 0);
        check("rerun_busy", 32'(dut.state_q == ST_ACCUM || dut.state_q == ST_WRITE), 1);
        reset = 1'b1;
        tick(1);
        check("final_rst_done", 32'(done), 0);
        check("final_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
